l1_miss_scheduler: RTL
======================

// Module: l1_miss_scheduler
// PURPOSE
// Shares one AXI master port between the L1 I-cache and L1 D-cache miss/write-through paths.
// Accepts one request per cache and round-robins between them when both request.
// Sequences exactly one AXI transaction at a time: a read burst (AR->R) or a single write (AW/W->B).
// Sits between L1C_inst/L1C_data and the AXI interconnect, replacing per-cache master ports.
// PARAMETERS
// ADDR_W      32  address width (AR/AW ADDR)
// DATA_W      32  data width (RDATA/WDATA); STRB width = DATA_W/8
// BURST_LEN   4   read beats per refill; ARLEN = BURST_LEN-1
// PORTS
// clk         in   1         clock
// rst_n       in   1         async active-low reset
// i_req       in   1         I-cache refill request; held with i_addr until i_done
// i_addr      in   ADDR_W    I-cache line base address
// d_req       in   1         D-cache request; held with d_* fields until d_done
// d_write     in   1         1 = single-beat write, 0 = read burst
// d_addr      in   ADDR_W    D-cache address
// d_wdata     in   DATA_W    write data
// d_wstrb     in   DATA_W/8  write strobes, forwarded unmodified to WSTRB
// i_rbeat/d_rbeat  out 1     R beat handshaken for this owner (same cycle as RVALID&&RREADY)
// rdata       out  DATA_W    RDATA pass-through, valid with *_rbeat
// i_done/d_done    out 1     one-cycle completion pulse (RESP state)
// i_err/d_err      out 1     valid with *_done: non-OKAY resp or beat-count mismatch
// AR*/R*/AW*/W*/B*  AXI master channels (ID=0 for I, 1 for D; SIZE=3'b010; BURST=INCR)
// BEHAVIOUR
// - Reset: FSM=IDLE, all VALIDs/READYs, *_rbeat, *_done, *_err = 0; last_owner = D (I wins first tie).
// - States: IDLE, AR, R, AWW, B, RESP.
// - IDLE: sample reqs; grant one, register owner, addr, write, wdata, wstrb.
//   Tie: grant != last_owner. Next state: AR (read) or AWW (d_write=1). No req: stay in IDLE.
// - AR: ARVALID=1, ARADDR/ARLEN/ARID stable until ARREADY; handshake -> R, beat counter=0.
// - R: RREADY=1.
//   - Each handshake: counter++, owner *_rbeat=1.
//   - RLAST handshake -> RESP.
//   - err if RRESP!=OKAY on any beat or RLAST beat index != BURST_LEN-1.
// - AWW: AWVALID and WVALID asserted together, AWLEN=0, WLAST=1.
//   - Each channel drops its VALID independently after its handshake, never re-asserts.
//   - Both done (same cycle or any order) -> B.
// - B: BREADY=1; BVALID handshake -> RESP; err if BRESP!=OKAY.
// - RESP: owner *_done=1 for exactly 1 cycle; last_owner=owner; -> IDLE.
//   - Requester must drop req before the next IDLE cycle.
// - Arbitration is sampled in IDLE only; a req rising mid-transaction waits; no preemption.
// - Latency: read miss with zero-wait slave = IDLE(1)+AR(1)+BURST_LEN beats+RESP(1).
// - err sticky across beats of one transaction, cleared on entering IDLE.
// - rst_n low mid-transaction: immediate return to IDLE with reset outputs; no completion pulse.
// - Handshake outputs not issued in the current state stay 0 (e.g. RREADY only in R, BREADY only in B).
// TESTING
// - i_req only, addr 0x0000_0040, slave 4 beats 0xA0..0xA3 -> ARADDR=0x40, ARLEN=3; 4 i_rbeat; i_done at cycle 7, i_err=0.
// - i_req and d_req (read, 0x1000_0010) same cycle after reset -> I burst completes, then D; D ARID=1.
// - Second simultaneous tie -> D granted (last_owner=I).
// - d_write, addr 0x1000_0004, wdata 0xDEADBEEF, strb 4'hF; AWREADY 2 cycles late, WREADY immediate.
//   -> WVALID drops after 1 cycle, AWVALID held 3 cycles, B then d_done.
// - Read with RRESP=SLVERR on beat 2 -> d_err=1 with d_done.
// - RLAST on beat 1 of 4 -> done with err=1.
// - rst_n asserted during R state beat 2 -> all outputs 0 next edge, FSM IDLE, no *_done.
// - ARREADY held low 10 cycles -> ARVALID/ARADDR stable throughout; i_req rising meanwhile is not granted.

Source files
------------

// File: rtl/l1_miss_scheduler.sv
// l1_miss_scheduler
// Shares one AXI master port between the L1 I-cache refill path and the
// L1 D-cache miss / write-through path. One request per cache is accepted,
// ties are broken round-robin, and exactly one AXI transaction is in flight
// at a time: either a read burst (AR->R) or a single-beat write (AW/W->B).
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   i_req, i_addr           I-cache refill request (held until i_done)
//   d_req, d_write, d_addr,
//   d_wdata, d_wstrb        D-cache request (held until d_done)
//   i_rbeat, d_rbeat        R beat accepted for that owner (same cycle)
//   rdata                   RDATA pass-through, valid with *_rbeat
//   i_done, d_done          one-cycle completion pulse
//   i_err, d_err            error flag, valid with *_done
//   ar_*, r_*, aw_*, w_*, b_*   AXI master channels (ID 0 = I, ID 1 = D)
module l1_miss_scheduler #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 4,
  parameter int ID_W      = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  input  logic                d_req,
  input  logic                d_write,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_wstrb,
  output logic                i_rbeat,
  output logic                d_rbeat,
  output logic [DATA_W-1:0]   rdata,
  output logic                i_done,
  output logic                d_done,
  output logic                i_err,
  output logic                d_err,
  output logic                ar_valid,
  input  logic                ar_ready,
  output logic [ADDR_W-1:0]   ar_addr,
  output logic [7:0]          ar_len,
  output logic [ID_W-1:0]     ar_id,
  output logic [2:0]          ar_size,
  output logic [1:0]          ar_burst,
  input  logic                r_valid,
  output logic                r_ready,
  input  logic [DATA_W-1:0]   r_data,
  input  logic [1:0]          r_resp,
  input  logic                r_last,
  output logic                aw_valid,
  input  logic                aw_ready,
  output logic [ADDR_W-1:0]   aw_addr,
  output logic [7:0]          aw_len,
  output logic [ID_W-1:0]     aw_id,
  output logic [2:0]          aw_size,
  output logic [1:0]          aw_burst,
  output logic                w_valid,
  input  logic                w_ready,
  output logic [DATA_W-1:0]   w_data,
  output logic [DATA_W/8-1:0] w_strb,
  output logic                w_last,
  input  logic                b_valid,
  output logic                b_ready,
  input  logic [1:0]          b_resp
);

  localparam logic [7:0] LAST_IDX = 8'(BURST_LEN - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_AR, ST_R, ST_AWW, ST_B, ST_RESP} state_t;

  state_t                state_reg, state_next;
  logic                  owner_reg;       // 0 = I-cache, 1 = D-cache
  logic                  last_owner_reg;
  logic [ADDR_W-1:0]     addr_reg;
  logic [DATA_W-1:0]     wdata_reg;
  logic [DATA_W/8-1:0]   wstrb_reg;
  logic [7:0]            beat_cnt_reg;
  logic                  err_reg;
  logic                  aw_done_reg, w_done_reg;
  logic                  resp_phase;

  // Tie goes to whoever did not own the previous transaction.
  logic grant_any, grant_d;
  assign grant_any = i_req | d_req;
  assign grant_d   = d_req & (~i_req | ~last_owner_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      owner_reg      <= 1'b0;
      last_owner_reg <= 1'b1;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wstrb_reg      <= '0;
      beat_cnt_reg   <= '0;
      err_reg        <= 1'b0;
      aw_done_reg    <= 1'b0;
      w_done_reg     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          err_reg      <= 1'b0;
          beat_cnt_reg <= '0;
          aw_done_reg  <= 1'b0;
          w_done_reg   <= 1'b0;
          if (grant_any) begin
            owner_reg <= grant_d;
            addr_reg  <= grant_d ? d_addr : i_addr;
            wdata_reg <= d_wdata;
            wstrb_reg <= d_wstrb;
          end
        end
        ST_R: begin
          if (r_valid) begin
            beat_cnt_reg <= beat_cnt_reg + 8'd1;
            // Error is sticky: any bad response, or RLAST arriving early/late.
            if ((r_resp != 2'b00) || (r_last && (beat_cnt_reg != LAST_IDX)))
              err_reg <= 1'b1;
          end
        end
        ST_AWW: begin
          if (aw_valid && aw_ready) aw_done_reg <= 1'b1;
          if (w_valid && w_ready)   w_done_reg  <= 1'b1;
        end
        ST_B: begin
          if (b_valid && (b_resp != 2'b00)) err_reg <= 1'b1;
        end
        ST_RESP: last_owner_reg <= owner_reg;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_next = state_reg;
    ar_valid   = 1'b0;
    r_ready    = 1'b0;
    aw_valid   = 1'b0;
    w_valid    = 1'b0;
    b_ready    = 1'b0;
    resp_phase = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (grant_any) state_next = (grant_d && d_write) ? ST_AWW : ST_AR;
      end
      ST_AR: begin
        ar_valid = 1'b1;
        if (ar_ready) state_next = ST_R;
      end
      ST_R: begin
        r_ready = 1'b1;
        if (r_valid && r_last) state_next = ST_RESP;
      end
      ST_AWW: begin
        // Each channel drops its VALID once handshaken and never re-raises it.
        aw_valid = ~aw_done_reg;
        w_valid  = ~w_done_reg;
        if ((aw_done_reg || aw_ready) && (w_done_reg || w_ready)) state_next = ST_B;
      end
      ST_B: begin
        b_ready = 1'b1;
        if (b_valid) state_next = ST_RESP;
      end
      ST_RESP: begin
        resp_phase = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign i_rbeat  = r_ready & r_valid & ~owner_reg;
  assign d_rbeat  = r_ready & r_valid &  owner_reg;
  assign rdata    = r_data;
  assign i_done   = resp_phase & ~owner_reg;
  assign d_done   = resp_phase &  owner_reg;
  assign i_err    = i_done & err_reg;
  assign d_err    = d_done & err_reg;

  assign ar_addr  = addr_reg;
  assign ar_len   = LAST_IDX;
  assign ar_id    = {{(ID_W-1){1'b0}}, owner_reg};
  assign ar_size  = 3'b010;
  assign ar_burst = 2'b01;

  assign aw_addr  = addr_reg;
  assign aw_len   = 8'd0;
  assign aw_id    = {{(ID_W-1){1'b0}}, owner_reg};
  assign aw_size  = 3'b010;
  assign aw_burst = 2'b01;
  assign w_data   = wdata_reg;
  assign w_strb   = wstrb_reg;
  assign w_last   = 1'b1;

endmodule
